// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state encoding,
// datapath widths, PC step and the default reset PC.
package if_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } if_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, inst} words for the decode stage.
// flush empties the buffer and overrides a simultaneous push.
// The head word reads as zero while the buffer is empty.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign dout_o  = empty_o ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; flush wins over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end

  // Storage array; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem[wr_ptr] <= din_i;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM port and buffers
// fetched words for decode. Handles branch redirect and halt.
// Optional build macro FETCH_PERF_EN adds fetch/stall performance counters.
//
// Decode handshake: id_valid_o means the head {id_pc_o, id_inst_o} is stable
// and valid; the word transfers on a rising edge where id_valid_o and
// id_ready_i are both 1. id_valid_o never depends on id_ready_i.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        halt_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  if_state_e         state_q;
  if_state_e         state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              fetch;
  logic              pop;
  logic              buf_full;
  logic              buf_empty;
  logic [CW-1:0]     buf_count;
  logic [63:0]       head;

  assign pop        = id_valid_o && id_ready_i;
  assign id_valid_o = !buf_empty;
  assign id_pc_o    = head[63:32];
  assign id_inst_o  = head[31:0];
  assign rom_addr_o = pc_q;
  assign rom_ce_o   = fetch;

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, fetch enable and next PC; a branch overrides the PC step.
  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    pc_d    = pc_q;
    case (state_q)
      S_BOOT: state_d = halt_i ? S_HALT : S_RUN;
      S_RUN: begin
        fetch = !branch_flag_i &&
                ((buf_count < CW'(BUF_DEPTH)) || (buf_full && pop));
        if (halt_i) state_d = S_HALT;
      end
      S_HALT: if (!halt_i) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    if (branch_flag_i) pc_d = align_pc(branch_target_i);
    else if (fetch)    pc_d = pc_q + PC_STEP;
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (64)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (branch_flag_i),
    .din_i   ({pc_q, rom_inst_i}),
    .dout_o  (head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic        full_stall;

  // A run cycle blocked only by a full, non-draining buffer.
  assign full_stall = (state_q == S_RUN) && !branch_flag_i && buf_full && !pop;
  assign perf_fetch_cnt_o = fetch_cnt;
  assign perf_stall_cnt_o = stall_cnt;

  // Free-running counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch)      fetch_cnt <= fetch_cnt + 32'd1;
      if (full_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the PC and drives the instruction ROM port (ce/addr/inst).
- Buffers fetched words in a small FIFO and hands {pc, inst} to the decode stage over a valid/ready handshake.
- Handles branch redirect (flush + new PC) and a halt request. Sits between inst_rom and the IF/ID boundary.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  32  ROM byte address; always word-aligned.
- rom_inst_i  in  32  ROM data; combinational, valid in the same cycle as ce/addr.
- id_valid_o  out  1  buffer head valid.
- id_ready_i  in  1  decode accepts head.
- id_pc_o  out  32  PC of head entry.
- id_inst_o  out  32  instruction of head entry.
- branch_flag_i  in  1  redirect request.
- branch_target_i  in  32  redirect PC.
- halt_i  in  1  suspend fetching.

Behaviour:
- Reset (asynchronous, rst=1):
  - pc=RESET_PC, state=S_BOOT, buffer empty.
  - rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- States:
  - S_BOOT: one cycle with ce=0. Next state is S_HALT if halt_i, else S_RUN.
  - S_RUN: fetching. halt_i=1 -> S_HALT.
  - S_HALT: ce=0; buffer still drains. halt_i=0 -> S_RUN.
- rom_addr_o = pc at all times. rom_ce_o is combinational.
- In S_RUN, rom_ce_o=1 iff branch_flag_i=0 and (count<BUF_DEPTH, or count==BUF_DEPTH with a pop this cycle).
- Fetch at a rising edge when rom_ce_o=1: push {pc, rom_inst_i}, then pc <= pc+4.
- pc arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 -> 0.
- Pop when id_valid_o && id_ready_i.
- id_* outputs are driven from the registered buffer head. Pop and push in the same cycle leave count unchanged.
- Latency: the first id_valid_o rises in the 2nd cycle after rst deasserts (BOOT, fetch, valid). Steady state is one instruction per cycle while id_ready_i=1.
- id_ready_i=0 with buffer full: ce drops to 0 and pc holds; no fetch is lost.
- Branch, when branch_flag_i=1 in any state:
  - A handshake in the same cycle still counts as accepted.
  - The whole buffer is flushed and no push occurs.
  - pc <= {branch_target_i[31:2], 2'b00} at the next edge.
  - The state is unchanged, except S_BOOT, which proceeds normally.
  - The earliest redirected instruction is valid 2 cycles after the branch cycle.
- Branch with halt: pc updates and the buffer flushes; fetch resumes at the target once halt_i falls.
- halt_i and branch_flag_i together: both apply.
- Reset mid-operation aborts everything immediately, with buffer contents discarded.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add two outputs:
  - perf_fetch_cnt_o (32): increments on every push.
  - perf_stall_cnt_o (32): increments on cycles in S_RUN with rom_ce_o=0 due to a full buffer.
- Both counters reset to 0, wrap modulo 2^32, and branch-suppressed cycles are excluded from the stall count.
- When not defined, the ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Package if_pkg: state encoding (S_BOOT, S_RUN, S_HALT), INST_W=32, ADDR_W=32, PC_STEP=4, default RESET_PC.
- Sub-module fetch_buf:
  - Synchronous FIFO of BUF_DEPTH x 64 bits ({pc, inst}).
  - Interfaces: push/pop/flush, full/empty/count.
  - flush takes priority over push.

Test Plan:
1. Reset release, id_ready_i=1, ROM word n = 32'h1000_0000+n:
   - ce=0 in cycle 0.
   - addr 0,4,8,… from cycle 1.
   - id_valid_o from cycle 2 with pc 0, inst 32'h10000000, then one per cycle.
2. Backpressure: id_ready_i=0 for 5 cycles after the first valid:
   - ce drops after 2 pushes and pc holds at 8.
   - On release, outputs resume pc 0,4,8 with no duplicates or gaps.
3. Branch: branch_flag_i=1, target 32'h0000_0103, while the buffer holds 2 entries:
   - The next edge leaves the buffer empty and pc=32'h100.
   - Next valid is pc 32'h100 two cycles later; flushed entries never appear.
4. Halt: halt_i=1 for 4 cycles mid-stream:
   - ce=0 and the buffer drains.
   - Fetch resumes at the held pc the cycle after halt_i falls.
5. Wrap and reset:
   - Branch to 32'hFFFF_FFFC: following pc is 0.
   - Assert rst asynchronously mid-cycle: outputs go to reset values before the next edge, and the restart fetches from RESET_PC.
6. Under FETCH_PERF_EN, scenario 2: perf_stall_cnt_o counts exactly the full-buffer cycles and perf_fetch_cnt_o equals the number of pushes.
